// File: rtl/ppi_pkg.sv
// Shared types and encodings for the nport handshake peripheral interface.
// No logic of its own; holds mode encoding, control-word fields and status helpers.
// Not applicable: no datapath or flow control lives here.
package ppi_pkg;

    // {strobed, direction}: bit 0 is the output direction, bit 1 selects handshake mode
    typedef enum logic [1:0] {
        BASIC_IN    = 2'b00,
        BASIC_OUT   = 2'b01,
        STROBED_IN  = 2'b10,
        STROBED_OUT = 2'b11
    } ppi_mode_e;

    // Control-word field positions (mode-set flag sits in the top data bit)
    localparam int unsigned CW_IDX_MSB = 6;
    localparam int unsigned CW_IDX_LSB = 3;
    localparam int unsigned CW_INTE    = 2;
    localparam int unsigned CW_DIR     = 1;
    localparam int unsigned CW_MODE    = 0;

    function automatic int unsigned mode_set_bit(input int unsigned w);
        return w - 1;
    endfunction

    // Status word: each port owns a pair of bits, buffer flag low, interrupt high
    function automatic int unsigned stat_flag_bit(input int unsigned port);
        return 2 * port;
    endfunction

    function automatic int unsigned stat_intr_bit(input int unsigned port);
        return 2 * port + 1;
    endfunction

    function automatic ppi_mode_e mode_from_cw(input logic strobed, input logic dir);
        return ppi_mode_e'({strobed, dir});
    endfunction

endpackage

// File: rtl/ppi_hs_channel.sv
// One port: pin/strobe synchronisers, edge detect, data latch, IBF/OBF_N/INTR and config.
// Pin edge to flag is 3 CLK edges; bus write/read effects land on the pulse edge.
// No backpressure: an input strobe arriving while IBF is set is dropped (overrun).
module ppi_hs_channel
    import ppi_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] pin,
    input  logic         stb_n,
    input  logic         ack_n,
    input  logic         cfg_wr,
    input  ppi_mode_e    cfg_mode,
    input  logic         cfg_inte,
    input  logic         data_wr,
    input  logic         data_rd,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic [W-1:0] pout,
    output logic         poe,
    output logic         ibf,
    output logic         obf_n,
    output logic         intr
);

    logic [W-1:0] pin_s1, pin_s2;
    logic         stb_s1, stb_s2, stb_q;
    logic         ack_s1, ack_s2, ack_q;
    logic         stb_fall, stb_rise, ack_fall, ack_rise;
    ppi_mode_e    mode;
    logic         inte;
    logic [W-1:0] latch;

    // Two-flop synchronisers plus one extra stage on the strobes for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pin_s1 <= '0;
            pin_s2 <= '0;
            stb_s1 <= 1'b1;
            stb_s2 <= 1'b1;
            stb_q  <= 1'b1;
            ack_s1 <= 1'b1;
            ack_s2 <= 1'b1;
            ack_q  <= 1'b1;
        end else begin
            pin_s1 <= pin;
            pin_s2 <= pin_s1;
            stb_s1 <= stb_n;
            stb_s2 <= stb_s1;
            stb_q  <= stb_s2;
            ack_s1 <= ack_n;
            ack_s2 <= ack_s1;
            ack_q  <= ack_s2;
        end
    end

    assign stb_fall = stb_q & ~stb_s2;
    assign stb_rise = ~stb_q & stb_s2;
    assign ack_fall = ack_q & ~ack_s2;
    assign ack_rise = ~ack_q & ack_s2;

    // Configuration, latch and handshake flags; a control write overrides everything else
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode  <= BASIC_IN;
            inte  <= 1'b0;
            latch <= '0;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
        end else if (cfg_wr) begin
            mode  <= cfg_mode;
            inte  <= cfg_inte;
            latch <= '0;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
        end else begin
            case (mode)
                BASIC_IN: begin
                end
                BASIC_OUT: begin
                    if (data_wr) latch <= wdat;
                end
                STROBED_IN: begin
                    // A read in the same cycle as a capture still sees the old latch on the bus
                    if (stb_fall && !ibf) begin
                        latch <= pin_s2;
                        ibf   <= 1'b1;
                    end else if (data_rd) begin
                        ibf   <= 1'b0;
                    end
                    if (data_rd)
                        intr <= 1'b0;
                    else if (stb_rise && ibf && inte)
                        intr <= 1'b1;
                end
                STROBED_OUT: begin
                    // A CPU write beats a coincident ACK fall so the new byte is never lost
                    if (data_wr) begin
                        latch <= wdat;
                        obf_n <= 1'b0;
                        intr  <= 1'b0;
                    end else begin
                        if (ack_fall) obf_n <= 1'b1;
                        if (ack_rise && inte) intr <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rdat = (mode == BASIC_IN) ? pin_s2 : latch;
    assign pout = latch;
    assign poe  = (mode == BASIC_OUT) || (mode == STROBED_OUT);

endmodule

// File: rtl/ppi_hs_nport.sv
// Top: CPU bus decode, control/status register, registered read data, NPORTS channels.
// DOUT/DOE one cycle after the read strobe; writes take effect on the sampling edge.
// No backpressure: every bus strobe is accepted once on its first low cycle.
module ppi_hs_nport
    import ppi_pkg::*;
#(
    parameter int W      = 8,
    parameter int NPORTS = 2,
    parameter int AW     = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CS_N,
    input  logic                RD_N,
    input  logic                WR_N,
    input  logic [AW-1:0]       A,
    input  logic [W-1:0]        DIN,
    output logic [W-1:0]        DOUT,
    output logic                DOE,
    input  logic [NPORTS*W-1:0] PIN,
    output logic [NPORTS*W-1:0] POUT,
    output logic [NPORTS-1:0]   POE,
    input  logic [NPORTS-1:0]   STB_N,
    input  logic [NPORTS-1:0]   ACK_N,
    output logic [NPORTS-1:0]   IBF,
    output logic [NPORTS-1:0]   OBF_N,
    output logic [NPORTS-1:0]   INTR
);

    localparam int unsigned SET_BIT = mode_set_bit(W);

    logic                rd_act, wr_act, rd_act_q, wr_act_q;
    logic                rd_pulse, wr_pulse;
    logic                ctl_sel;
    logic [3:0]          ctl_idx;
    ppi_mode_e           cfg_mode;
    logic [NPORTS-1:0]   cfg_wr, data_wr, data_rd;
    logic [NPORTS*W-1:0] ch_rdat;
    logic [W-1:0]        status;
    logic [W-1:0]        rd_mux;

    assign rd_act   = ~CS_N & ~RD_N;
    assign wr_act   = ~CS_N & ~WR_N;
    assign wr_pulse = wr_act & ~wr_act_q;
    // Write has priority: a read overlapping a write never produces a read pulse
    assign rd_pulse = rd_act & ~rd_act_q & ~wr_act;

    assign ctl_sel  = wr_pulse && (A == AW'(NPORTS)) && DIN[SET_BIT];
    assign ctl_idx  = DIN[CW_IDX_MSB:CW_IDX_LSB];
    assign cfg_mode = mode_from_cw(DIN[CW_MODE], DIN[CW_DIR]);

    genvar i;
    generate
        for (i = 0; i < NPORTS; i++) begin : g_port
            localparam int unsigned FB = stat_flag_bit(i);
            localparam int unsigned IB = stat_intr_bit(i);

            // Out-of-range indices match no port, so such control writes fall away
            assign cfg_wr[i]  = ctl_sel && (ctl_idx == 4'(i));
            assign data_wr[i] = wr_pulse && (A == AW'(i));
            assign data_rd[i] = rd_pulse && (A == AW'(i));

            assign status[FB] = POE[i] ? ~OBF_N[i] : IBF[i];
            assign status[IB] = INTR[i];

            ppi_hs_channel #(.W(W)) u_ch (
                .CLK      (CLK),
                .RESET    (RESET),
                .pin      (PIN[i*W +: W]),
                .stb_n    (STB_N[i]),
                .ack_n    (ACK_N[i]),
                .cfg_wr   (cfg_wr[i]),
                .cfg_mode (cfg_mode),
                .cfg_inte (DIN[CW_INTE]),
                .data_wr  (data_wr[i]),
                .data_rd  (data_rd[i]),
                .wdat     (DIN),
                .rdat     (ch_rdat[i*W +: W]),
                .pout     (POUT[i*W +: W]),
                .poe      (POE[i]),
                .ibf      (IBF[i]),
                .obf_n    (OBF_N[i]),
                .intr     (INTR[i])
            );
        end
        if (2 * NPORTS < W) begin : g_stat_pad
            assign status[W-1:2*NPORTS] = '0;
        end
    endgenerate

    // Read-data select: port registers, then status, anything above reads as zero
    always_comb begin
        rd_mux = '0;
        if (A == AW'(NPORTS)) rd_mux = status;
        for (int p = 0; p < NPORTS; p++) begin
            if (A == AW'(p)) rd_mux = ch_rdat[p*W +: W];
        end
    end

    // Strobe history for pulse detection and the registered read port
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
            DOE      <= 1'b0;
            DOUT     <= '0;
        end else begin
            rd_act_q <= rd_act;
            wr_act_q <= wr_act;
            DOE      <= rd_act;
            if (rd_pulse) DOUT <= rd_mux;
        end
    end

endmodule
